ovmon_ctrl: RTL and testbench

//  Multi-channel digital supervisor for the sky130 overvoltage comparator array.
//  Per channel: synchronises the raw comparator output, drives the registered

---
 rtl/ovmon_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ovmon_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ovmon_ctrl.sv
// Digital supervisor for an array of overvoltage comparators: synchronises each
// comparator, blanks after enable/trip-code changes, debounces and reports status.
module ovmon_ctrl #(
  parameter int NCH       = 4,
  parameter int TRIP_W    = 4,
  parameter int DB_W      = 8,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NCH-1:0]        cmp_raw,
  input  logic [NCH*TRIP_W-1:0] otrip_in,
  input  logic [DB_W-1:0]       db_len,
  input  logic                  latch_mode,
  input  logic [NCH-1:0]        clr,
  output logic [NCH*TRIP_W-1:0] otrip,
  output logic                  ana_ena,
  output logic [NCH-1:0]        ovout,
  output logic [NCH-1:0]        ov_sticky,
  output logic                  ov_any,
  output logic [NCH-1:0]        blank
);

  localparam int BC_W = $clog2(BLANK_CYC + 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_MON   = 2'd2
  } state_t;

  state_t                state_r      [NCH];
  state_t                state_nx_s   [NCH];
  logic [BC_W-1:0]       blank_cnt_r  [NCH];
  logic [BC_W-1:0]       blank_cnt_nx_s [NCH];
  logic [DB_W-1:0]       db_cnt_r     [NCH];
  logic [DB_W-1:0]       db_cnt_nx_s  [NCH];
  logic [NCH-1:0]        sync1_r;
  logic [NCH-1:0]        cmp_s_r;
  logic [NCH-1:0]        ovout_r;
  logic [NCH-1:0]        ovout_nx_s;
  logic [NCH-1:0]        ovout_q_r;
  logic [NCH-1:0]        pend_r;
  logic [NCH-1:0]        pend_nx_s;
  logic [NCH-1:0]        sticky_r;
  logic [NCH-1:0]        sticky_nx_s;
  logic [NCH-1:0]        trip_chg_s;
  logic [NCH-1:0]        mismatch_s;
  logic [NCH*TRIP_W-1:0] otrip_r;
  logic                  ana_ena_r;
  logic [DB_W-1:0]       len_eff_s;

  assign len_eff_s = (db_len == {DB_W{1'b0}}) ? {{(DB_W-1){1'b0}}, 1'b1} : db_len;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign trip_chg_s[g] = otrip_in[g*TRIP_W +: TRIP_W] != otrip_r[g*TRIP_W +: TRIP_W];
    assign mismatch_s[g] = cmp_s_r[g] ^ ovout_r[g];
    assign blank[g]      = (state_r[g] == ST_BLANK);
  end

  assign otrip     = otrip_r;
  assign ana_ena   = ana_ena_r;
  assign ovout     = ovout_r;
  assign ov_sticky = sticky_r;
  assign ov_any    = |ovout_r;

  // Next-state and datapath decode for every channel FSM plus sticky flags.
  always_comb begin
    ovout_nx_s  = ovout_r;
    pend_nx_s   = pend_r;
    sticky_nx_s = (ovout_r & ~ovout_q_r) | (sticky_r & ~clr);
    for (int i = 0; i < NCH; i++) begin
      state_nx_s[i]     = state_r[i];
      blank_cnt_nx_s[i] = blank_cnt_r[i];
      db_cnt_nx_s[i]    = db_cnt_r[i];
      case (state_r[i])
        ST_OFF: begin
          ovout_nx_s[i]     = 1'b0;
          pend_nx_s[i]      = 1'b0;
          db_cnt_nx_s[i]    = {DB_W{1'b0}};
          blank_cnt_nx_s[i] = {BC_W{1'b0}};
          if (ena) begin
            state_nx_s[i]     = ST_BLANK;
            blank_cnt_nx_s[i] = BC_W'(BLANK_CYC);
          end else begin
            state_nx_s[i] = ST_OFF;
          end
        end
        ST_BLANK: begin
          if (!ena) begin
            state_nx_s[i]     = ST_OFF;
            ovout_nx_s[i]     = 1'b0;
            pend_nx_s[i]      = 1'b0;
            db_cnt_nx_s[i]    = {DB_W{1'b0}};
            blank_cnt_nx_s[i] = {BC_W{1'b0}};
          end else if (trip_chg_s[i]) begin
            blank_cnt_nx_s[i] = BC_W'(BLANK_CYC);
          end else if (blank_cnt_r[i] <= BC_W'(1)) begin
            state_nx_s[i]  = ST_MON;
            db_cnt_nx_s[i] = {DB_W{1'b0}};
          end else begin
            blank_cnt_nx_s[i] = blank_cnt_r[i] - BC_W'(1);
          end
        end
        ST_MON: begin
          if (!ena) begin
            state_nx_s[i]     = ST_OFF;
            ovout_nx_s[i]     = 1'b0;
            pend_nx_s[i]      = 1'b0;
            db_cnt_nx_s[i]    = {DB_W{1'b0}};
            blank_cnt_nx_s[i] = {BC_W{1'b0}};
          end else if (trip_chg_s[i]) begin
            state_nx_s[i]     = ST_BLANK;
            blank_cnt_nx_s[i] = BC_W'(BLANK_CYC);
            db_cnt_nx_s[i]    = {DB_W{1'b0}};
          end else if (clr[i] && pend_r[i]) begin
            // A latched high is released only once the low level has debounced.
            ovout_nx_s[i]  = 1'b0;
            pend_nx_s[i]   = 1'b0;
            db_cnt_nx_s[i] = {DB_W{1'b0}};
          end else if (mismatch_s[i]) begin
            if (({1'b0, db_cnt_r[i]} + {{DB_W{1'b0}}, 1'b1}) >= {1'b0, len_eff_s}) begin
              db_cnt_nx_s[i] = {DB_W{1'b0}};
              if (ovout_r[i] && latch_mode) begin
                pend_nx_s[i] = 1'b1;
              end else begin
                ovout_nx_s[i] = ~ovout_r[i];
                pend_nx_s[i]  = 1'b0;
              end
            end else if (db_cnt_r[i] == {DB_W{1'b1}}) begin
              db_cnt_nx_s[i] = db_cnt_r[i];
            end else begin
              db_cnt_nx_s[i] = db_cnt_r[i] + {{(DB_W-1){1'b0}}, 1'b1};
            end
          end else begin
            db_cnt_nx_s[i] = {DB_W{1'b0}};
            pend_nx_s[i]   = 1'b0;
          end
        end
        default: begin
          state_nx_s[i]     = ST_OFF;
          ovout_nx_s[i]     = 1'b0;
          pend_nx_s[i]      = 1'b0;
          db_cnt_nx_s[i]    = {DB_W{1'b0}};
          blank_cnt_nx_s[i] = {BC_W{1'b0}};
        end
      endcase
    end
  end

  // Synchroniser, analog-facing registers and per-channel state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r   <= {NCH{1'b0}};
      cmp_s_r   <= {NCH{1'b0}};
      ana_ena_r <= 1'b0;
      otrip_r   <= {(NCH*TRIP_W){1'b0}};
      ovout_r   <= {NCH{1'b0}};
      ovout_q_r <= {NCH{1'b0}};
      pend_r    <= {NCH{1'b0}};
      sticky_r  <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        state_r[i]     <= ST_OFF;
        blank_cnt_r[i] <= {BC_W{1'b0}};
        db_cnt_r[i]    <= {DB_W{1'b0}};
      end
    end else begin
      sync1_r   <= cmp_raw;
      cmp_s_r   <= sync1_r;
      ana_ena_r <= ena;
      if (ena) begin
        otrip_r <= otrip_in;
      end else begin
        otrip_r <= otrip_r;
      end
      ovout_r   <= ovout_nx_s;
      ovout_q_r <= ovout_r;
      pend_r    <= pend_nx_s;
      sticky_r  <= sticky_nx_s;
      for (int i = 0; i < NCH; i++) begin
        state_r[i]     <= state_nx_s[i];
        blank_cnt_r[i] <= blank_cnt_nx_s[i];
        db_cnt_r[i]    <= db_cnt_nx_s[i];
      end
    end
  end

endmodule

// File: tb/tb_ovmon_ctrl.sv
// Directed testbench for ovmon_ctrl: blanking, debounce, trip-code change,
// latch mode, disable and asynchronous reset, with hand-computed expectations.
module tb_ovmon_ctrl;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [3:0]  cmp_raw;
  logic [15:0] otrip_in;
  logic [7:0]  db_len;
  logic        latch_mode;
  logic [3:0]  clr;
  logic [15:0] otrip;
  logic        ana_ena;
  logic [3:0]  ovout;
  logic [3:0]  ov_sticky;
  logic        ov_any;
  logic [3:0]  blank;

  int checks;
  int errors;

  ovmon_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .cmp_raw    (cmp_raw),
    .otrip_in   (otrip_in),
    .db_len     (db_len),
    .latch_mode (latch_mode),
    .clr        (clr),
    .otrip      (otrip),
    .ana_ena    (ana_ena),
    .ovout      (ovout),
    .ov_sticky  (ov_sticky),
    .ov_any     (ov_any),
    .blank      (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; cmp_raw = 4'h0; otrip_in = 16'hFFFF;
    db_len = 8'd4; latch_mode = 1'b0; clr = 4'h0;
    tick(3);
    checks++; if (ovout !== 4'h0) begin errors++; $display("FAIL reset_ovout got %h exp 0", ovout); end
    checks++; if (ov_sticky !== 4'h0) begin errors++; $display("FAIL reset_sticky got %h exp 0", ov_sticky); end
    checks++; if (blank !== 4'h0) begin errors++; $display("FAIL reset_blank got %h exp 0", blank); end
    checks++; if (ana_ena !== 1'b0 || ov_any !== 1'b0) begin errors++; $display("FAIL reset_ena_any got %b%b exp 00", ana_ena, ov_any); end
    checks++; if (otrip !== 16'h0000) begin errors++; $display("FAIL reset_otrip got %h exp 0000", otrip); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_enable_blank();
    int nblank;
    ena = 1'b1;
    checks++; if (ana_ena !== 1'b0) begin errors++; $display("FAIL ana_ena_early got %b exp 0", ana_ena); end
    tick(1);
    checks++; if (ana_ena !== 1'b1) begin errors++; $display("FAIL ana_ena_rise got %b exp 1", ana_ena); end
    checks++; if (otrip !== 16'hFFFF) begin errors++; $display("FAIL otrip_load got %h exp ffff", otrip); end
    nblank = 0;
    for (int k = 0; k < 20; k++) begin
      if (blank == 4'hF) nblank++;
      tick(1);
    end
    checks++; if (nblank !== 16) begin errors++; $display("FAIL blank_len got %0d exp 16", nblank); end
    checks++; if (blank !== 4'h0) begin errors++; $display("FAIL blank_end got %h exp 0", blank); end
  endtask

  task automatic test_debounce_rise();
    cmp_raw = 4'b0001;
    tick(5);
    checks++; if (ovout !== 4'b0000) begin errors++; $display("FAIL rise_early got %h exp 0", ovout); end
    tick(1);
    checks++; if (ovout !== 4'b0001) begin errors++; $display("FAIL rise_ovout got %h exp 1", ovout); end
    checks++; if (ov_sticky !== 4'b0000) begin errors++; $display("FAIL rise_sticky_early got %h exp 0", ov_sticky); end
    checks++; if (ov_any !== 1'b1) begin errors++; $display("FAIL rise_any got %b exp 1", ov_any); end
    tick(1);
    checks++; if (ov_sticky !== 4'b0001) begin errors++; $display("FAIL rise_sticky got %h exp 1", ov_sticky); end
  endtask

  task automatic test_glitch();
    cmp_raw = 4'b0011;
    tick(3);
    cmp_raw = 4'b0001;
    tick(10);
    checks++; if (ovout !== 4'b0001) begin errors++; $display("FAIL glitch_ovout got %h exp 1", ovout); end
    checks++; if (ov_sticky !== 4'b0001) begin errors++; $display("FAIL glitch_sticky got %h exp 1", ov_sticky); end
    db_len = 8'd0;
    cmp_raw = 4'b0011;
    tick(1);
    cmp_raw = 4'b0001;
    tick(1);
    checks++; if (ovout !== 4'b0001) begin errors++; $display("FAIL len0_early got %h exp 1", ovout); end
    tick(1);
    checks++; if (ovout !== 4'b0011) begin errors++; $display("FAIL len0_rise got %h exp 3", ovout); end
    tick(1);
    checks++; if (ovout !== 4'b0001) begin errors++; $display("FAIL len0_fall got %h exp 1", ovout); end
    checks++; if (ov_sticky !== 4'b0011) begin errors++; $display("FAIL len0_sticky got %h exp 3", ov_sticky); end
    db_len = 8'd4;
    clr = 4'b0010;
    tick(1);
    clr = 4'b0000;
    checks++; if (ov_sticky !== 4'b0001) begin errors++; $display("FAIL clr_sticky got %h exp 1", ov_sticky); end
    tick(2);
  endtask

  task automatic test_trip_change();
    int bad;
    otrip_in = 16'hFFFA;
    cmp_raw = 4'b0000;
    tick(1);
    checks++; if (otrip !== 16'hFFFA) begin errors++; $display("FAIL trip_otrip got %h exp fffa", otrip); end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (blank !== 4'b0001 || ovout !== 4'b0001) bad++;
      if (k < 15) tick(1);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL trip_blank_hold got %0d bad cycles exp 0", bad); end
    tick(1);
    checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL trip_blank_end got %h exp 0", blank); end
    tick(3);
    checks++; if (ovout !== 4'b0001) begin errors++; $display("FAIL trip_follow_early got %h exp 1", ovout); end
    tick(1);
    checks++; if (ovout !== 4'b0000) begin errors++; $display("FAIL trip_follow got %h exp 0", ovout); end
  endtask

  task automatic test_latch();
    latch_mode = 1'b1;
    clr = 4'b0001;
    tick(1);
    clr = 4'b0000;
    checks++; if (ov_sticky !== 4'b0000) begin errors++; $display("FAIL latch_pre_clr got %h exp 0", ov_sticky); end
    cmp_raw = 4'b0001;
    tick(7);
    checks++; if (ovout !== 4'b0001 || ov_sticky !== 4'b0001) begin errors++; $display("FAIL latch_trip got %h/%h exp 1/1", ovout, ov_sticky); end
    cmp_raw = 4'b0000;
    tick(12);
    checks++; if (ovout !== 4'b0001) begin errors++; $display("FAIL latch_hold got %h exp 1", ovout); end
    clr = 4'b0001;
    tick(1);
    clr = 4'b0000;
    checks++; if (ovout !== 4'b0000 || ov_sticky !== 4'b0000) begin errors++; $display("FAIL latch_clr got %h/%h exp 0/0", ovout, ov_sticky); end
    cmp_raw = 4'b0001;
    tick(7);
    checks++; if (ovout !== 4'b0001 || ov_sticky !== 4'b0001) begin errors++; $display("FAIL latch_retrip got %h/%h exp 1/1", ovout, ov_sticky); end
    clr = 4'b0001;
    tick(1);
    clr = 4'b0000;
    checks++; if (ovout !== 4'b0001 || ov_sticky !== 4'b0000) begin errors++; $display("FAIL latch_clr_high got %h/%h exp 1/0", ovout, ov_sticky); end
    latch_mode = 1'b0;
  endtask

  task automatic test_disable();
    ena = 1'b0;
    otrip_in = 16'h1234;
    tick(1);
    checks++; if (ovout !== 4'h0 || blank !== 4'h0 || ana_ena !== 1'b0) begin errors++; $display("FAIL disable got %h/%h/%b exp 0/0/0", ovout, blank, ana_ena); end
    checks++; if (otrip !== 16'hFFFA) begin errors++; $display("FAIL disable_otrip got %h exp fffa", otrip); end
    otrip_in = 16'hFFFA;
    tick(1);
    ena = 1'b1;
    tick(1);
    checks++; if (blank !== 4'hF) begin errors++; $display("FAIL reenable_blank got %h exp f", blank); end
  endtask

  task automatic test_rst_mid();
    cmp_raw = 4'hF;
    tick(26);
    checks++; if (ovout !== 4'hF || ov_sticky !== 4'hF) begin errors++; $display("FAIL all_trip got %h/%h exp f/f", ovout, ov_sticky); end
    cmp_raw = 4'h0;
    tick(3);
    #2 rst = 1'b1;
    #1;
    checks++; if (ovout !== 4'h0 || ov_sticky !== 4'h0 || ov_any !== 1'b0) begin errors++; $display("FAIL rst_async got %h/%h/%b exp 0/0/0", ovout, ov_sticky, ov_any); end
    checks++; if (otrip !== 16'h0000 || ana_ena !== 1'b0 || blank !== 4'h0) begin errors++; $display("FAIL rst_async_ana got %h/%b/%h exp 0/0/0", otrip, ana_ena, blank); end
    tick(1);
    rst = 1'b0;
    tick(1);
    checks++; if (blank !== 4'hF || ana_ena !== 1'b1) begin errors++; $display("FAIL rst_reenter got %h/%b exp f/1", blank, ana_ena); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_enable_blank();
    test_debounce_rise();
    test_glitch();
    test_trip_change();
    test_latch();
    test_disable();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
